// File: rtl/mem_pkg.sv
// Shared opcode and fault-code constants plus FSM state type for the MEM-stage
// data-memory/stack access controller.
package mem_pkg;

  localparam logic [5:0] OP_LW   = 6'b000101;
  localparam logic [5:0] OP_SW   = 6'b000110;
  localparam logic [5:0] OP_PUSH = 6'b001111;
  localparam logic [5:0] OP_POP  = 6'b010000;
  localparam logic [5:0] OP_CALL = 6'b010010;
  localparam logic [5:0] OP_RET  = 6'b010011;

  localparam logic [1:0] FLT_NONE  = 2'd0;
  localparam logic [1:0] FLT_ALIGN = 2'd1;
  localparam logic [1:0] FLT_RANGE = 2'd2;
  localparam logic [1:0] FLT_STACK = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_PUSH, OP_POP, OP_CALL, OP_RET};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-addressed req/ack data-memory bus between the MEM-stage controller
// (master) and the data memory (slave).
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_addr_check.sv
// Combinational target-address, write-enable and fault classification for one
// memory-class opcode given the effective address and current stack pointer.
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned STACK_TOP  = 1024,
  parameter int unsigned STACK_BASE = 512
) (
  input  logic [5:0]  opcode,
  input  logic [31:0] op_addr,
  input  logic [31:0] sp,
  output logic [31:0] addr,
  output logic        we,
  output logic [1:0]  fault_code
);

  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);
  // Bounds folded onto sp so neither sp-4 nor sp+4 can wrap in the compare.
  localparam logic [31:0] PUSH_MIN = 32'(STACK_BASE + 4);
  localparam logic [31:0] POP_MAX  = 32'(STACK_TOP - 4);

  always_comb begin
    addr       = op_addr;
    we         = 1'b0;
    fault_code = FLT_NONE;
    case (opcode)
      OP_LW, OP_SW: begin
        we = (opcode == OP_SW);
        if (op_addr[1:0] != 2'b00)  fault_code = FLT_ALIGN;
        else if (op_addr > ADDR_MAX) fault_code = FLT_RANGE;
      end
      OP_PUSH, OP_CALL: begin
        addr = sp - 32'd4;
        we   = 1'b1;
        if (sp < PUSH_MIN) fault_code = FLT_STACK;
      end
      OP_POP, OP_RET: begin
        addr = sp;
        if (sp > POP_MAX) fault_code = FLT_STACK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for data memory and stack: accepts one LW/SW/PUSH/POP/
// CALL/RET at a time, owns SP, and runs a req/ack transfer unless the op faults.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = 1024,
  parameter int unsigned STACK_TOP  = 1024,
  parameter int unsigned STACK_BASE = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [31:0] op_pc,
  output logic        op_done,
  output logic        op_fault,
  output logic [1:0]  fault_code,
  output logic [31:0] rdata,
  output logic [31:0] ret_pc,
  output logic        ret_valid,
  output logic [31:0] sp_out,
  mem_access_ctrl_if.master mem
);

  state_t      state;
  logic [31:0] sp;
  logic [5:0]  op_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] ck_addr;
  logic        ck_we;
  logic [1:0]  ck_fault;

  mem_addr_check #(
    .MEM_BYTES (MEM_BYTES),
    .STACK_TOP (STACK_TOP),
    .STACK_BASE(STACK_BASE)
  ) u_check (
    .opcode    (opcode),
    .op_addr   (op_addr),
    .sp        (sp),
    .addr      (ck_addr),
    .we        (ck_we),
    .fault_code(ck_fault)
  );

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign sp_out        = sp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sp         <= 32'(STACK_TOP);
      op_q       <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_ready   <= 1'b1;
      op_done    <= 1'b0;
      op_fault   <= 1'b0;
      fault_code <= FLT_NONE;
      ret_valid  <= 1'b0;
      rdata      <= '0;
      ret_pc     <= '0;
    end else begin
      // Completion flags are single-cycle; only the DONE entry raises them.
      op_done    <= 1'b0;
      op_fault   <= 1'b0;
      fault_code <= FLT_NONE;
      ret_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid && is_mem_op(opcode)) begin
            op_q     <= opcode;
            op_ready <= 1'b0;
            if (ck_fault != FLT_NONE) begin
              op_done    <= 1'b1;
              op_fault   <= 1'b1;
              fault_code <= ck_fault;
              state      <= ST_DONE;
            end else begin
              addr_q  <= ck_addr;
              we_q    <= ck_we;
              wdata_q <= (opcode == OP_CALL) ? op_pc : op_wdata;
              req_q   <= 1'b1;
              state   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_ack) begin
            case (op_q)
              OP_LW, OP_POP:    rdata  <= mem.mem_rdata;
              OP_RET:           ret_pc <= mem.mem_rdata;
              default: ;
            endcase
            case (op_q)
              OP_PUSH, OP_CALL: sp <= sp - 32'd4;
              OP_POP, OP_RET:   sp <= sp + 32'd4;
              default: ;
            endcase
            req_q     <= 1'b0;
            op_done   <= 1'b1;
            ret_valid <= (op_q == OP_RET);
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          req_q    <= 1'b0;
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, corner-case
// sequences and randomized ops against a stack-depth/memory reference model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int unsigned TOP  = 1024;
  localparam int unsigned BASE = 512;
  localparam int unsigned MAXD = (TOP - BASE) / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [5:0]  opcode = '0;
  logic [31:0] op_addr = '0, op_wdata = '0, op_pc = '0;
  logic        op_done, op_fault, ret_valid;
  logic [1:0]  fault_code;
  logic [31:0] rdata, ret_pc, sp_out;

  always #5 clk = ~clk;

  mem_access_ctrl_if mif();

  mem_access_ctrl #(.MEM_BYTES(1024), .STACK_TOP(1024), .STACK_BASE(512)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .op_addr(op_addr), .op_wdata(op_wdata), .op_pc(op_pc),
    .op_done(op_done), .op_fault(op_fault), .fault_code(fault_code),
    .rdata(rdata), .ret_pc(ret_pc), .ret_valid(ret_valid), .sp_out(sp_out),
    .mem(mif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];
  int unsigned depth;
  logic [31:0] ref_rdata, ref_retpc;
  logic [1:0]  e_fault;
  logic [31:0] e_addr, e_wd;
  logic        e_we, e_rv;

  int unsigned r_lat, r_nreq;
  logic [31:0] r_a0, r_d0, r_rdata, r_retpc, r_sp;
  logic        r_we0, r_stable, r_fault, r_rv, r_ready, r_done;
  logic [1:0]  r_fcode;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr, wd, pc;
    int unsigned waits;
    logic [1:0]  fault;
    logic [31:0] maddr, sp, rd, rpc;
    logic        rv;
  } vec_t;
  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    depth = 0; ref_rdata = '0; ref_retpc = '0;
  endtask

  // Stack modelled as a depth count: slot k (1-based) lives at TOP-4k.
  task automatic model_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] pc);
    e_fault = FLT_NONE; e_addr = a; e_we = 1'b0; e_wd = wd; e_rv = 1'b0;
    if (opc == OP_LW || opc == OP_SW) begin
      e_we = (opc == OP_SW);
      if (a % 4 != 0) e_fault = FLT_ALIGN;
      else if (a > TOP - 4) e_fault = FLT_RANGE;
      else if (e_we) ref_mem[a / 4] = wd;
      else ref_rdata = ref_mem[a / 4];
    end else if (opc == OP_PUSH || opc == OP_CALL) begin
      e_we = 1'b1;
      e_wd = (opc == OP_CALL) ? pc : wd;
      if (depth == MAXD) e_fault = FLT_STACK;
      else begin
        depth++;
        e_addr = 32'(TOP - 4 * depth);
        ref_mem[e_addr / 4] = e_wd;
      end
    end else begin
      if (depth == 0) e_fault = FLT_STACK;
      else begin
        e_addr = 32'(TOP - 4 * depth);
        if (opc == OP_RET) begin ref_retpc = ref_mem[e_addr / 4]; e_rv = 1'b1; end
        else ref_rdata = ref_mem[e_addr / 4];
        depth--;
      end
    end
  endtask

  task automatic do_reset();
    op_valid = 1'b0; mif.mem_ack = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Issues one op and plays the memory with `waits` stall cycles before ack.
  task automatic do_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] pc, input int unsigned waits);
    int unsigned c;
    c = 0;
    while (!op_ready && c < 20) begin @(posedge clk); #1; c++; end
    op_valid = 1'b1; opcode = opc; op_addr = a; op_wdata = wd; op_pc = pc;
    @(posedge clk); #1;
    op_valid = 1'b0; opcode = '0;
    c = 1; r_nreq = 0; r_stable = 1'b1; r_done = 1'b0; r_lat = 0;
    r_a0 = '0; r_we0 = 1'b0; r_d0 = '0;
    while (!r_done && c <= 40) begin
      mif.mem_ack = 1'b0;
      mif.mem_rdata = $urandom;
      if (mif.mem_req) begin
        if (r_nreq == 0) begin r_a0 = mif.mem_addr; r_we0 = mif.mem_we; r_d0 = mif.mem_wdata; end
        else if (mif.mem_addr !== r_a0 || mif.mem_we !== r_we0 || mif.mem_wdata !== r_d0)
          r_stable = 1'b0;
        r_nreq++;
        if (r_nreq == waits + 1) begin
          mif.mem_ack = 1'b1;
          mif.mem_rdata = env_mem[mif.mem_addr[9:2]];
          if (mif.mem_we) env_mem[mif.mem_addr[9:2]] = mif.mem_wdata;
        end
      end
      if (op_done) begin
        r_done = 1'b1; r_lat = c;
        r_fault = op_fault; r_fcode = fault_code; r_rdata = rdata; r_retpc = ret_pc;
        r_rv = ret_valid; r_sp = sp_out; r_ready = op_ready;
      end else begin
        @(posedge clk); #1; c++;
      end
    end
    mif.mem_ack = 1'b0;
    chk("op_done_within_budget", r_done, 1'b1);
  endtask

  task automatic check_vs_model(input int unsigned waits);
    chk("latency", r_lat, (e_fault != FLT_NONE) ? 32'd1 : 32'(waits + 2));
    chk("req_cycles", r_nreq, (e_fault != FLT_NONE) ? 32'd0 : 32'(waits + 1));
    chk("fault_code", r_fcode, e_fault);
    chk("op_fault", r_fault, e_fault != FLT_NONE);
    if (e_fault == FLT_NONE) begin
      chk("mem_addr", r_a0, e_addr);
      chk("mem_we", r_we0, e_we);
      if (e_we) chk("mem_wdata", r_d0, e_wd);
      chk("req_stable", r_stable, 1'b1);
    end
    chk("rdata", r_rdata, ref_rdata);
    chk("ret_pc", r_retpc, ref_retpc);
    chk("ret_valid", r_rv, e_rv);
    chk("sp_out", r_sp, 32'(TOP - 4 * depth));
    chk("ready_low_in_done", r_ready, 1'b0);
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] ro;
    logic [31:0] ra;
    int unsigned w;

    ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_PUSH;
    ops[3] = OP_POP; ops[4] = OP_CALL; ops[5] = OP_RET;
    for (int i = 0; i < 256; i++) begin env_mem[i] = '0; ref_mem[i] = '0; end
    mif.mem_ack = 1'b0; mif.mem_rdata = '0;

    //          op       addr          wdata         pc     w  fault      maddr  sp    rdata         ret_pc rv
    tbl[0]  = '{OP_SW,   32'h10,       32'hDEADBEEF, 32'h0,  0, FLT_NONE,  32'h10, 1024, 32'h0,        32'h0,  1'b0};
    tbl[1]  = '{OP_LW,   32'h10,       32'h0,        32'h0,  2, FLT_NONE,  32'h10, 1024, 32'hDEADBEEF, 32'h0,  1'b0};
    tbl[2]  = '{OP_PUSH, 32'h0,        32'h11111111, 32'h0,  0, FLT_NONE,  1020,   1020, 32'hDEADBEEF, 32'h0,  1'b0};
    tbl[3]  = '{OP_CALL, 32'h0,        32'h0,        32'h40, 1, FLT_NONE,  1016,   1016, 32'hDEADBEEF, 32'h0,  1'b0};
    tbl[4]  = '{OP_RET,  32'h0,        32'h0,        32'h0,  0, FLT_NONE,  1016,   1020, 32'hDEADBEEF, 32'h40, 1'b1};
    tbl[5]  = '{OP_POP,  32'h0,        32'h0,        32'h0,  3, FLT_NONE,  1020,   1024, 32'h11111111, 32'h40, 1'b0};
    tbl[6]  = '{OP_LW,   32'h13,       32'h0,        32'h0,  0, FLT_ALIGN, 32'h0,  1024, 32'h11111111, 32'h40, 1'b0};
    tbl[7]  = '{OP_LW,   1024,         32'h0,        32'h0,  0, FLT_RANGE, 32'h0,  1024, 32'h11111111, 32'h40, 1'b0};
    tbl[8]  = '{OP_POP,  32'h0,        32'h0,        32'h0,  0, FLT_STACK, 32'h0,  1024, 32'h11111111, 32'h40, 1'b0};
    tbl[9]  = '{OP_RET,  32'h0,        32'h0,        32'h0,  0, FLT_STACK, 32'h0,  1024, 32'h11111111, 32'h40, 1'b0};
    tbl[10] = '{OP_SW,   1020,         32'hA5A5A5A5, 32'h0,  0, FLT_NONE,  1020,   1024, 32'h11111111, 32'h40, 1'b0};
    tbl[11] = '{OP_LW,   1020,         32'h0,        32'h0,  1, FLT_NONE,  1020,   1024, 32'hA5A5A5A5, 32'h40, 1'b0};
    tbl[12] = '{OP_SW,   32'h2,        32'h5,        32'h0,  0, FLT_ALIGN, 32'h0,  1024, 32'hA5A5A5A5, 32'h40, 1'b0};
    tbl[13] = '{OP_LW,   32'hFFFFFFFC, 32'h0,        32'h0,  0, FLT_RANGE, 32'h0,  1024, 32'hA5A5A5A5, 32'h40, 1'b0};

    do_reset();
    chk("reset_sp", sp_out, 32'd1024);
    chk("reset_ready", op_ready, 1'b1);
    chk("reset_req", mif.mem_req, 1'b0);
    chk("reset_done", op_done, 1'b0);
    chk("reset_fault_code", fault_code, 2'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_ret_pc", ret_pc, 32'h0);

    for (int i = 0; i < 14; i++) begin
      model_op(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].pc);
      do_op(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].pc, tbl[i].waits);
      chk($sformatf("tbl%0d_latency", i), r_lat,
          (tbl[i].fault != FLT_NONE) ? 32'd1 : 32'(tbl[i].waits + 2));
      chk($sformatf("tbl%0d_req_cycles", i), r_nreq,
          (tbl[i].fault != FLT_NONE) ? 32'd0 : 32'(tbl[i].waits + 1));
      chk($sformatf("tbl%0d_fault_code", i), r_fcode, tbl[i].fault);
      chk($sformatf("tbl%0d_op_fault", i), r_fault, tbl[i].fault != FLT_NONE);
      if (tbl[i].fault == FLT_NONE) begin
        chk($sformatf("tbl%0d_mem_addr", i), r_a0, tbl[i].maddr);
        chk($sformatf("tbl%0d_stable", i), r_stable, 1'b1);
      end
      chk($sformatf("tbl%0d_sp", i), r_sp, tbl[i].sp);
      chk($sformatf("tbl%0d_rdata", i), r_rdata, tbl[i].rd);
      chk($sformatf("tbl%0d_ret_pc", i), r_retpc, tbl[i].rpc);
      chk($sformatf("tbl%0d_ret_valid", i), r_rv, tbl[i].rv);
    end

    // Unlisted opcode and a stray ack in IDLE must both be ignored.
    @(posedge clk); #1;
    op_valid = 1'b1; opcode = 6'b000000; op_addr = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("ignored_ready", op_ready, 1'b1);
      chk("ignored_req", mif.mem_req, 1'b0);
      chk("ignored_done", op_done, 1'b0);
    end
    op_valid = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mif.mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("stray_ack_ready", op_ready, 1'b1);
    chk("stray_ack_req", mif.mem_req, 1'b0);
    chk("stray_ack_done", op_done, 1'b0);
    chk("stray_ack_rdata", rdata, ref_rdata);
    chk("stray_ack_sp", sp_out, 32'(TOP - 4 * depth));

    // Fill the stack to STACK_BASE, then one more push must overflow.
    do_reset();
    for (int i = 0; i < 128; i++) begin
      model_op(OP_PUSH, 32'h0, 32'(i) ^ 32'h5A000000, 32'h0);
      do_op(OP_PUSH, 32'h0, 32'(i) ^ 32'h5A000000, 32'h0, 0);
      check_vs_model(0);
    end
    model_op(OP_PUSH, 32'h0, 32'hFFFF0000, 32'h0);
    do_op(OP_PUSH, 32'h0, 32'hFFFF0000, 32'h0, 1);
    check_vs_model(1);
    chk("overflow_code", r_fcode, FLT_STACK);
    chk("overflow_sp", r_sp, 32'd512);

    // Randomized ops from the overflowed state.
    for (int i = 0; i < 250; i++) begin
      ro = ops[$urandom_range(0, 5)];
      ra = 32'($urandom_range(0, 1100));
      if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
      w = $urandom_range(0, 3);
      model_op(ro, ra, $urandom, $urandom);
      do_op(ro, ra, e_wd, e_wd, w);
      check_vs_model(w);
    end

    // Reset while a request is outstanding.
    do_reset();
    model_op(OP_PUSH, 32'h0, 32'h12345678, 32'h0);
    do_op(OP_PUSH, 32'h0, 32'h12345678, 32'h0, 0);
    check_vs_model(0);
    @(posedge clk); #1;
    op_valid = 1'b1; opcode = OP_PUSH; op_wdata = 32'h87654321;
    @(posedge clk); #1;
    op_valid = 1'b0; opcode = '0;
    chk("midreset_req_up", mif.mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_req_drop", mif.mem_req, 1'b0);
    chk("midreset_sp", sp_out, 32'd1024);
    chk("midreset_ready", op_ready, 1'b1);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      mif.mem_ack = 1'b1;
      @(posedge clk); #1;
      chk("midreset_no_done", op_done, 1'b0);
      chk("midreset_no_req", mif.mem_req, 1'b0);
    end
    mif.mem_ack = 1'b0;
    chk("midreset_sp_after", sp_out, 32'd1024);
    chk("midreset_rdata", rdata, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator side of the data-memory/stack interface; sits in the CPU MEM stage between the pipeline and the byte-addressed data memory.
- Accepts one memory-class instruction at a time: LW, SW, PUSH, POP, CALL, RET.
- Owns the stack pointer and checks alignment, range and stack bounds.
- Drives a req/ack handshake to the memory and reports completion, read data and return PC to the pipeline.

Parameters:
- MEM_BYTES, 1024, size of data memory in bytes; valid word addresses are 0..MEM_BYTES-4.
- STACK_TOP, 1024, SP reset value; empty-stack SP (first push writes STACK_TOP-4).
- STACK_BASE, 512, lowest legal stack word address; a push below it is an overflow.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  pipeline presents an op
- op_ready  out  1  controller can accept (state IDLE)
- opcode  in  6  LW=000101, SW=000110, PUSH=001111, POP=010000, CALL=010010, RET=010011
- op_addr  in  32  effective address for LW/SW
- op_wdata  in  32  store data for SW and PUSH
- op_pc  in  32  return address pushed by CALL
- op_done  out  1  one-cycle completion pulse
- op_fault  out  1  valid with op_done; op aborted
- fault_code  out  2  0 none, 1 misaligned, 2 out of range, 3 stack over/underflow
- rdata  out  32  LW/POP data, valid with op_done
- ret_pc  out  32  RET target, valid with op_done
- ret_valid  out  1  pulses with op_done on successful RET
- sp_out  out  32  current stack pointer
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, always 4-aligned
- mem_wdata  out  32  little-endian word
- mem_ack  in  1  memory completes request this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset (async, immediate):
  - state=IDLE, sp=STACK_TOP.
  - mem_req=0, op_done=0, op_fault=0, fault_code=0, ret_valid=0, rdata=0, ret_pc=0.
  - op_ready=1.
- FSM states: IDLE, REQ, DONE.
- IDLE: op_ready=1. Accept happens when op_valid=1 and opcode is one of the six listed.
  - Unlisted opcodes with op_valid=1 are ignored: no state change, no pulse.
  - On accept, compute the target address and check faults:
    - LW/SW: addr=op_addr. Fault 1 if addr[1:0]!=0, else fault 2 if addr>MEM_BYTES-4.
    - PUSH/CALL: addr=sp-4. Fault 3 if sp-4<STACK_BASE.
    - POP/RET: addr=sp. Fault 3 if sp+4>STACK_TOP.
  - On fault: go to DONE with the fault latched; no memory traffic.
  - Otherwise: latch addr, we (SW/PUSH/CALL) and wdata (op_wdata, or op_pc for CALL), then go to REQ.
- REQ:
  - mem_req=1 with mem_addr/mem_we/mem_wdata held stable until mem_ack=1.
  - mem_ack may arrive in the first REQ cycle.
  - On the ack cycle:
    - reads capture mem_rdata into rdata (POP/LW) or ret_pc (RET);
    - sp updates: PUSH/CALL sp<=sp-4, POP/RET sp<=sp+4, LW/SW no change;
    - go to DONE.
- DONE:
  - op_done=1 for exactly one cycle; op_fault/fault_code/ret_valid valid in the same cycle.
  - op_ready=0; return to IDLE next cycle.
- Latency: accept at cycle T; mem_req first high at T+1; with zero-wait ack, op_done at T+2. A faulted op gives op_done at T+1.
- Throughput: at most one op per 3 cycles, or 2 for a faulted op.
- Held values: rdata and ret_pc hold their last value until overwritten; a faulted op leaves them and sp unchanged.
- mem_ack while mem_req=0 is ignored.
- sp_out equals the sp register at all times; no wrap-around is possible because bounds are checked before update.
- Reset during REQ: mem_req drops asynchronously and the op is lost; the memory must tolerate an abandoned request.

Decomposition:
- Shared package mem_pkg holds:
  - opcode constants OP_LW, OP_SW, OP_PUSH, OP_POP, OP_CALL, OP_RET;
  - fault-code constants FLT_NONE, FLT_ALIGN, FLT_RANGE, FLT_STACK;
  - the FSM state typedef.
- One natural sub-module: mem_addr_check, purely combinational. Inputs are opcode, op_addr and sp; outputs are target addr, we and fault_code.

Test Plan:
- Reset: rst_n low, then high → sp_out=1024, op_ready=1, mem_req=0. Then SW op_addr=0x10, op_wdata=0xDEADBEEF with ack held high → mem_req at T+1, mem_addr=0x10, mem_we=1, op_done at T+2, op_fault=0.
- Load with wait states: LW addr 0x10, mem_ack delayed 3 cycles, mem_rdata=0xDEADBEEF → mem_req held 3 cycles with stable address, rdata=0xDEADBEEF with op_done.
- Stack sequence: PUSH 0x11111111 → mem_addr=1020, sp_out=1020. CALL op_pc=0x40 → mem_addr=1016, sp_out=1016. RET with mem_rdata=0x40 → ret_pc=0x40, ret_valid=1, sp_out=1020. POP → sp_out=1024.
- Faults:
  - LW addr 0x13 → fault_code=1, op_done at T+1, no mem_req.
  - LW addr 1024 → fault_code=2.
  - POP at sp=1024 → fault_code=3, sp unchanged.
  - 128 PUSHes fill the stack (sp=512); the 129th PUSH → fault_code=3, sp_out=512.
- Reset mid-op: assert rst_n low while in REQ before ack → mem_req=0 the same cycle, no op_done, sp_out=1024.
- Ignored traffic: op_valid with opcode 000000 → no accept, op_ready stays 1. A mem_ack pulse in IDLE → no state change.
